// File: rtl/of_scoreboard_ctrl_pkg.sv
// Shared pipeline definitions: operand source types, size encodings, register count
// and the size-to-mask helper used by decode and operand fetch.
package of_scoreboard_ctrl_pkg;

  localparam int PIPE_NREGS = 16;
  localparam int PIPE_DW    = 64;

  typedef enum logic [1:0] {
    SRC_REGISTER = 2'b00,
    SRC_MEMORY   = 2'b01,
    SRC_IMM      = 2'b10
  } src_type_e;

  typedef enum logic [1:0] {
    SZ_8  = 2'b00,
    SZ_16 = 2'b01,
    SZ_32 = 2'b10,
    SZ_64 = 2'b11
  } op_size_e;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_8:    m = 64'h0000_0000_0000_00FF;
      SZ_16:   m = 64'h0000_0000_0000_FFFF;
      SZ_32:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/of_scoreboard_ctrl_scoreboard.sv
// Register busy scoreboard: issue sets a bit, writeback clears it, flush wipes all.
module of_scoreboard
  import of_scoreboard_ctrl_pkg::*;
#(
  parameter int NREGS = PIPE_NREGS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     set_en_i,
  input  logic [$clog2(NREGS)-1:0] set_reg_i,
  input  logic                     clr_en_i,
  input  logic [$clog2(NREGS)-1:0] clr_reg_i,
  input  logic                     flush_i,
  output logic [NREGS-1:0]         sb_o
);

  logic [NREGS-1:0] sb_q, sb_d;

  // Set is applied after clear so a same-cycle set/clear on one register leaves it busy.
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_reg_i] = 1'b0;
    if (set_en_i) sb_d[set_reg_i] = 1'b1;
    if (flush_i)  sb_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sb_q <= '0;
    else          sb_q <= sb_d;
  end

  assign sb_o = sb_q;

endmodule

// File: rtl/of_scoreboard_ctrl.sv
// Operand-fetch stage: hazard check against the scoreboard, operand masking and
// the registered handoff to execute with a valid/ready handshake.
module of_scoreboard_ctrl
  import of_scoreboard_ctrl_pkg::*;
#(
  parameter int NREGS = PIPE_NREGS,
  parameter int DW    = PIPE_DW
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [7:0]               dec_op,
  input  logic [1:0]               dec_srcty,
  input  logic [$clog2(NREGS)-1:0] dec_srcreg,
  input  logic [$clog2(NREGS)-1:0] dec_dstreg,
  input  logic                     dec_dst_wr,
  input  logic [DW-1:0]            dec_imm,
  input  logic [1:0]               dec_size,
  output logic [$clog2(NREGS)-1:0] rf_rd_addr1,
  output logic [$clog2(NREGS)-1:0] rf_rd_addr2,
  input  logic [DW-1:0]            rf_rd_data1,
  input  logic [DW-1:0]            rf_rd_data2,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [7:0]               ex_op,
  output logic [DW-1:0]            ex_oper1,
  output logic [DW-1:0]            ex_oper2,
  output logic [$clog2(NREGS)-1:0] ex_dstreg,
  output logic [1:0]               ex_size,
  input  logic                     wb_valid,
  input  logic [$clog2(NREGS)-1:0] wb_reg,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy_mask,
  output logic [15:0]              stall_cnt
);

  logic [NREGS-1:0]         sb;
  logic                     hazard, issue;
  logic [DW-1:0]            mask_w, oper1_d, oper2_d;
  logic                     ex_valid_q, ex_valid_d;
  logic [7:0]               ex_op_q;
  logic [DW-1:0]            ex_oper1_q, ex_oper2_q;
  logic [$clog2(NREGS)-1:0] ex_dstreg_q;
  logic [1:0]               ex_size_q;
  logic [15:0]              stall_cnt_q, stall_cnt_d;

  assign hazard    = sb[dec_dstreg] | ((dec_srcty == SRC_REGISTER) & sb[dec_srcreg]);
  assign dec_ready = !flush & !hazard & (!ex_valid_q | ex_ready);
  assign issue     = dec_valid & dec_ready;

  of_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en_i  (issue & dec_dst_wr),
    .set_reg_i (dec_dstreg),
    .clr_en_i  (wb_valid),
    .clr_reg_i (wb_reg),
    .flush_i   (flush),
    .sb_o      (sb)
  );

  // Memory operands arrive already sized by the load path, so they bypass masking.
  always_comb begin
    mask_w  = DW'(size_mask(dec_size));
    oper1_d = rf_rd_data1 & mask_w;
    case (dec_srcty)
      SRC_REGISTER: oper2_d = rf_rd_data2 & mask_w;
      SRC_MEMORY:   oper2_d = dec_imm;
      default:      oper2_d = dec_imm & mask_w;
    endcase
  end

  always_comb begin
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush)         ex_valid_d = 1'b0;
    else if (issue)    ex_valid_d = 1'b1;
    else if (ex_ready) ex_valid_d = 1'b0;
    if (dec_valid & hazard & !flush & (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_oper1_q  <= '0;
      ex_oper2_q  <= '0;
      ex_dstreg_q <= '0;
      ex_size_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (issue) begin
        ex_op_q     <= dec_op;
        ex_oper1_q  <= oper1_d;
        ex_oper2_q  <= oper2_d;
        ex_dstreg_q <= dec_dstreg;
        ex_size_q   <= dec_size;
      end
    end
  end

  assign rf_rd_addr1 = dec_dstreg;
  assign rf_rd_addr2 = dec_srcreg;
  assign ex_valid    = ex_valid_q;
  assign ex_op       = ex_op_q;
  assign ex_oper1    = ex_oper1_q;
  assign ex_oper2    = ex_oper2_q;
  assign ex_dstreg   = ex_dstreg_q;
  assign ex_size     = ex_size_q;
  assign busy_mask   = sb;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_of_scoreboard_ctrl.sv
// Random-stimulus bench for of_scoreboard_ctrl against a behavioural pipeline model.
module tb_of_scoreboard_ctrl;

  logic        clk, reset_n;
  logic        dec_valid, dec_ready, dec_dst_wr;
  logic [7:0]  dec_op;
  logic [1:0]  dec_srcty, dec_size;
  logic [3:0]  dec_srcreg, dec_dstreg;
  logic [63:0] dec_imm;
  logic [3:0]  rf_rd_addr1, rf_rd_addr2;
  logic [63:0] rf_rd_data1, rf_rd_data2;
  logic        ex_valid, ex_ready;
  logic [7:0]  ex_op;
  logic [63:0] ex_oper1, ex_oper2;
  logic [3:0]  ex_dstreg;
  logic [1:0]  ex_size;
  logic        wb_valid, flush;
  logic [3:0]  wb_reg;
  logic [15:0] busy_mask, stall_cnt;

  logic [63:0] regs [16];
  assign rf_rd_data1 = regs[dec_dstreg];
  assign rf_rd_data2 = regs[dec_srcreg];

  of_scoreboard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_srcty(dec_srcty), .dec_srcreg(dec_srcreg), .dec_dstreg(dec_dstreg),
    .dec_dst_wr(dec_dst_wr), .dec_imm(dec_imm), .dec_size(dec_size),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_oper1(ex_oper1), .ex_oper2(ex_oper2), .ex_dstreg(ex_dstreg), .ex_size(ex_size),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit          busy [16];
  bit          m_exv;
  logic [7:0]  m_op;
  logic [63:0] m_o1, m_o2;
  logic [3:0]  m_dst;
  logic [1:0]  m_sz;
  int          m_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] trunc(input logic [63:0] v, input logic [1:0] sz);
    int bits;
    bits = 8 << sz;
    if (bits == 64) return v;
    return v % (64'd1 << bits);
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (busy[i]) m = m | (16'd1 << i);
    return m;
  endfunction

  task automatic model_reset();
    m_exv = 0; m_op = '0; m_o1 = '0; m_o2 = '0; m_dst = '0; m_sz = '0; m_stall = 0;
    for (int i = 0; i < 16; i++) busy[i] = 0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    bit hz, rdy, iss;
    #1;
    hz  = busy[dec_dstreg] || (dec_srcty == 2'd0 && busy[dec_srcreg]);
    rdy = !flush && !hz && (!m_exv || ex_ready);
    iss = dec_valid && rdy;
    chk("dec_ready", dec_ready, rdy);
    chk("rd_addr1", rf_rd_addr1, dec_dstreg);
    chk("rd_addr2", rf_rd_addr2, dec_srcreg);
    if (dec_valid && hz && !flush && m_stall < 65535) m_stall++;
    if (flush) begin
      m_exv = 0;
      for (int i = 0; i < 16; i++) busy[i] = 0;
    end else begin
      if (wb_valid) busy[wb_reg] = 0;
      if (iss && dec_dst_wr) busy[dec_dstreg] = 1;
      if (iss) begin
        m_exv = 1;
        m_op  = dec_op;
        m_dst = dec_dstreg;
        m_sz  = dec_size;
        m_o1  = trunc(regs[dec_dstreg], dec_size);
        if (dec_srcty == 2'd0)      m_o2 = trunc(regs[dec_srcreg], dec_size);
        else if (dec_srcty == 2'd1) m_o2 = dec_imm;
        else                        m_o2 = trunc(dec_imm, dec_size);
      end else if (ex_ready) begin
        m_exv = 0;
      end
    end
    @(posedge clk); #1;
    chk("ex_valid", ex_valid, m_exv);
    chk("busy_mask", busy_mask, model_mask());
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_exv) begin
      chk("ex_op", ex_op, m_op);
      chk("ex_oper1", ex_oper1, m_o1);
      chk("ex_oper2", ex_oper2, m_o2);
      chk("ex_dstreg", ex_dstreg, m_dst);
      chk("ex_size", ex_size, m_sz);
    end
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_op = '0; dec_srcty = 2'd2; dec_srcreg = '0; dec_dstreg = '0;
    dec_dst_wr = 0; dec_imm = '0; dec_size = '0; ex_ready = 1; wb_valid = 0; wb_reg = '0; flush = 0;
  endtask

  task automatic rand_inputs();
    dec_valid  = ($urandom_range(0, 3) != 0);
    dec_op     = 8'($urandom);
    dec_srcty  = 2'($urandom_range(0, 2));
    dec_srcreg = 4'($urandom_range(0, 15));
    dec_dstreg = 4'($urandom_range(0, 15));
    dec_dst_wr = 1'($urandom_range(0, 1));
    dec_imm    = {$urandom, $urandom};
    dec_size   = 2'($urandom);
    ex_ready   = ($urandom_range(0, 9) < 7);
    wb_valid   = ($urandom_range(0, 2) == 0);
    wb_reg     = 4'($urandom_range(0, 15));
    flush      = ($urandom_range(0, 39) == 0);
    if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 15)] = {$urandom, $urandom};
  endtask

  // Asynchronous reset pulse in mid-cycle, released on the falling edge.
  task automatic reset_pulse();
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_op", ex_op, 0);
    chk("rst_ex_oper1", ex_oper1, 0);
    chk("rst_ex_oper2", ex_oper2, 0);
    chk("rst_ex_dstreg", ex_dstreg, 0);
    chk("rst_ex_size", ex_size, 0);
    chk("rst_busy_mask", busy_mask, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = {$urandom, $urandom};
    idle_inputs();
    reset_n = 1;
    model_reset();
    #2;
    reset_pulse();

    // ADD RAX <- RCX, 64-bit; issued in the first cycle after reset release
    dec_valid = 1; dec_op = 8'h01; dec_dstreg = 4'd0; dec_dst_wr = 1;
    dec_srcty = 2'd0; dec_srcreg = 4'd1; dec_size = 2'b11;
    regs[1] = 64'h1234_5678_9ABC_DEF0;
    step();
    chk("add_oper2", ex_oper2, 64'h1234_5678_9ABC_DEF0);
    chk("add_busy", busy_mask, 16'h0001);

    // reader of RAX stalls until writeback, then issues the following cycle
    dec_srcty = 2'd2; dec_dst_wr = 0; dec_dstreg = 4'd0;
    step();
    chk("raw_stall", stall_cnt, 1);
    wb_valid = 1; wb_reg = 4'd0;
    step();
    chk("raw_no_bypass", ex_valid, 0);
    wb_valid = 0;
    step();
    chk("raw_issue_after_wb", ex_valid, 1);

    // immediate masked to 8 bits, memory operand passed whole
    dec_dstreg = 4'd2; dec_srcty = 2'd2; dec_size = 2'b00; dec_imm = 64'hFFFF_FFFF_FFFF_FF80;
    step();
    chk("imm8_oper2", ex_oper2, 64'h80);
    dec_srcty = 2'd1; dec_size = 2'b01;
    step();
    chk("mem16_oper2", ex_oper2, 64'hFFFF_FFFF_FFFF_FF80);

    // set wins over same-cycle writeback of R8
    dec_dstreg = 4'd8; dec_dst_wr = 1; wb_valid = 1; wb_reg = 4'd8;
    step();
    chk("set_wins_r8", busy_mask[8], 1);
    idle_inputs();
    step();

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset_pulse();
      end
      rand_inputs();
      step();
    end

    // hold a hazard long enough to saturate the stall counter
    idle_inputs();
    flush = 1;
    step();
    flush = 0; dec_valid = 1; dec_dstreg = 4'd5; dec_dst_wr = 1; dec_srcty = 2'd2;
    step();
    for (int n = 0; n < 65600; n++) step();
    chk("stall_saturate", stall_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/of_scoreboard_ctrl.md
OF_SCOREBOARD_CTRL -- requirements
Module: of_scoreboard_ctrl

Interface
REQ-001 SHALL have parameter NREGS, default 16, meaning architectural register count.
REQ-002 SHALL have parameter DW, default 64, meaning operand width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- dec_valid  in  1  decoded instruction offered.
- dec_ready  out  1  instruction accepted this cycle.
- dec_op  in  8  operation code.
- dec_srcty  in  2  source type: REGISTER / MEMORY / IMM.
- dec_srcreg  in  4  source register.
- dec_dstreg  in  4  destination register, also read as operand 1.
- dec_dst_wr  in  1  instruction writes dec_dstreg.
- dec_imm  in  64  immediate, or memory operand value.
- dec_size  in  2  operand size: 00=8, 01=16, 10=32, 11=64 bits.
- rf_rd_addr1  out  4  register-file read port 1 address (= dec_dstreg).
- rf_rd_addr2  out  4  register-file read port 2 address (= dec_srcreg).
- rf_rd_data1  in  64  combinational read data, port 1.
- rf_rd_data2  in  64  combinational read data, port 2.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute accepts.
- ex_op  out  8  registered operation code.
- ex_oper1  out  64  registered operand 1.
- ex_oper2  out  64  registered operand 2.
- ex_dstreg  out  4  registered destination register.
- ex_size  out  2  registered operand size.
- wb_valid  in  1  writeback retiring a register.
- wb_reg  in  4  register being written back.
- flush  in  1  squash in-flight work.
- busy_mask  out  16  scoreboard contents.
- stall_cnt  out  16  hazard stall cycle count.

Function
REQ-005 SHALL compute hazard = sb[dec_dstreg] | (dec_srcty==REGISTER & sb[dec_srcreg]), using the registered scoreboard sb.
REQ-006 SHALL drive dec_ready = !flush & !hazard & (!ex_valid | ex_ready); an issue occurs when dec_valid & dec_ready.
REQ-007 On issue, SHALL register op, dstreg and size, and set ex_valid next cycle; accept-to-ex_valid latency is exactly 1 cycle.
REQ-008 ex_oper1 SHALL be rf_rd_data1 masked to dec_size, with upper bits zero.
REQ-009 ex_oper2 SHALL be:
- REGISTER: rf_rd_data2 masked to size.
- IMM: dec_imm masked to size.
- MEMORY: dec_imm unmasked, all 64 bits, for every size.
REQ-010 ex_valid & !ex_ready SHALL hold every ex_* output stable.
REQ-011 ex_valid SHALL clear on (ex_ready & no issue).
REQ-012 Issue with dec_dst_wr=1 SHALL set sb[dec_dstreg].
REQ-013 wb_valid SHALL clear sb[wb_reg].
REQ-014 Same-cycle set and clear of the same bit: set SHALL win.
REQ-015 There SHALL be no wb-to-dec bypass; a waiting instruction issues the cycle after sb clears.
REQ-016 wb_valid on a register not busy SHALL be harmless (no change).
REQ-017 flush SHALL force dec_ready=0, and next cycle ex_valid=0 and sb all-zero; it overrides issue, wb and ex handshake.
REQ-018 stall_cnt SHALL increment each cycle dec_valid & hazard & !flush, and saturate at 16'hFFFF.
REQ-019 busy_mask SHALL equal sb.

Reset
REQ-020 reset_n low SHALL asynchronously force ex_valid=0, sb=0, stall_cnt=0, and ex_op, ex_oper1, ex_oper2, ex_dstreg, ex_size = 0.
REQ-021 Reset asserted mid-stall or mid-handshake SHALL discard the held instruction; the first issue is possible in the first cycle after reset deassertion.

Structure
REQ-022 The operand-type enum (REGISTER, MEMORY, IMM), the size encodings and NREGS SHALL live in the shared pipeline package, reused by decode and operand fetch.
REQ-023 Scoreboard set/clear/flush logic SHALL be one sub-module, of_scoreboard; masking and output registers stay in the top.

Verification
REQ-024 Scenario: issue op=ADD, dst=RAX wr=1, srcty=REGISTER src=RCX, size=11, RCX=0x1234_5678_9ABC_DEF0 -> next cycle ex_valid=1, oper2=0x123456789ABCDEF0, busy_mask=0x0001.
REQ-025 Scenario: then issue reading RAX while sb[0]=1 -> dec_ready=0 and stall_cnt increments; wb_valid, wb_reg=0 at cycle N -> issue at N+1.
REQ-026 Scenario: size=00, srcty=IMM, dec_imm=0xFFFF_FFFF_FFFF_FF80 -> ex_oper2=0x80; size=01 with srcty=MEMORY, same value -> ex_oper2 unchanged.
REQ-027 Scenario: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable and dec_ready=0; ex_ready=1 with a new issue pending -> back-to-back transfer with no bubble.
REQ-028 Scenario: issue setting sb[R8] in the same cycle as wb_valid, wb_reg=R8 -> busy_mask[8]=1.
REQ-029 Scenario: flush with ex_valid=1, busy_mask=0x00F0 -> next cycle ex_valid=0, busy_mask=0; reset_n pulse mid-stall -> all outputs 0 and stall_cnt=0.
